// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: drives all eight {A,B,C} input vectors into a small
// circuit under test, holds each for HOLD_CYCLES cycles, samples the {D,E}
// response at the end of the hold and compares it against a golden table.
// Results (pass, fail_count, first_fail, captured table) persist until the
// next accepted start.
// Optional feature: define TT_SWEEP_CHECKER_MISR_EN to add an 8-bit MISR
// signature of the sampled responses on sig_o.
`timescale 1ns/1ps
module tt_sweep_checker #(
  parameter int unsigned HOLD_CYCLES = 20,
  parameter logic [15:0] EXPECTED    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [2:0]  abc_o,
  input  logic        d_i,
  input  logic        e_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [2:0]  first_fail,
  output logic [15:0] table_o
`ifdef TT_SWEEP_CHECKER_MISR_EN
  ,
  output logic [7:0]  sig_o
`endif
);

  // Sample point of each vector: the last cycle of its hold window.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  vec;
  logic [7:0]  hold_cnt;
  logic        start_ok;
  logic        sample;
  logic [1:0]  resp;
  logic [1:0]  resp_exp;
  logic        mismatch;

  assign start_ok = (state == ST_IDLE) && start;
  assign sample   = (state == ST_DRIVE) && (hold_cnt == HOLD_LAST);
  assign resp     = {d_i, e_i};
  assign resp_exp = EXPECTED[{vec, 1'b0} +: 2];
  assign mismatch = (resp != resp_exp);

  // vec only changes while driving, so it doubles as the held stimulus.
  assign abc_o = vec;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        busy = 1'b1;
        if (sample && (vec == 3'd7)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Vector sequencing, response capture and mismatch accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= 3'd0;
      hold_cnt   <= 8'd0;
      pass       <= 1'b0;
      fail_count <= 4'd0;
      first_fail <= 3'd0;
      table_o    <= 16'h0000;
    end else if (start_ok) begin
      vec        <= 3'd0;
      hold_cnt   <= 8'd0;
      pass       <= 1'b0;
      fail_count <= 4'd0;
      first_fail <= 3'd0;
      table_o    <= 16'h0000;
    end else if (state == ST_DRIVE) begin
      if (sample) begin
        hold_cnt                  <= 8'd0;
        table_o[{vec, 1'b0} +: 2] <= resp;
        if (mismatch) begin
          fail_count <= fail_count + 4'd1;
          if (fail_count == 4'd0) first_fail <= vec;
        end
        if (vec != 3'd7) begin
          vec <= vec + 3'd1;
        end else begin
          // Verdict is registered on entry to DONE so it is valid with done.
          pass <= (fail_count == 4'd0) && !mismatch;
        end
      end else begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

`ifdef TT_SWEEP_CHECKER_MISR_EN
  logic [7:0] misr_nxt;

  // MISR step: x^8+x^6+x^5+x^4+1, response folded into the two low bits.
  always_comb begin
    misr_nxt = {sig_o[6:0], 1'b0} ^ (sig_o[7] ? 8'h71 : 8'h00) ^ {6'b000000, resp};
  end

  // Signature register, seeded on reset and on each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_o <= 8'hFF;
    end else if (start_ok) begin
      sig_o <= 8'hFF;
    end else if (sample) begin
      sig_o <= misr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: three instances with different
// parameters share clock and reset; each accepted start pushes the expected
// sweep result, and a per-instance monitor pops and compares on done.
`timescale 1ns/1ps
module tb_tt_sweep_checker;

  typedef struct {
    longint      t0;
    int          lat;
    logic        pass;
    logic [3:0]  fc;
    logic [2:0]  ff;
    logic [15:0] tbl;
    logic [7:0]  sig;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic tie0_b = 1'b0, flip_a = 1'b0;

  logic [2:0]  abc_a, abc_b, abc_c;
  logic        d_a, e_a, d_b, e_b, d_c, e_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [3:0]  fc_a, fc_b, fc_c;
  logic [2:0]  ff_a, ff_b, ff_c;
  logic [15:0] tbl_a, tbl_b, tbl_c;
  logic [7:0]  sig_a, sig_b, sig_c;

  int n_checks = 0;
  int n_err = 0;
  exp_t q_a[$], q_b[$], q_c[$];
  logic [7:0] sig_hist_a[$];
  logic pd_a = 1'b0, pd_b = 1'b0, pd_c = 1'b0;

  // Circuit under test: D = A&B, E = ~C, with fault hooks.
  assign d_a = abc_a[2] & abc_a[1];
  assign e_a = ~abc_a[0] ^ (flip_a && (abc_a == 3'd3));
  assign d_b = tie0_b ? 1'b0 : (abc_b[2] & abc_b[1]);
  assign e_b = tie0_b ? 1'b0 : ~abc_b[0];
  assign d_c = abc_c[2] & abc_c[1];
  assign e_c = ~abc_c[0];

  tt_sweep_checker #(.HOLD_CYCLES(20), .EXPECTED(16'hB111)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abc_o(abc_a), .d_i(d_a), .e_i(e_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a),
    .first_fail(ff_a), .table_o(tbl_a)
`ifdef TT_SWEEP_CHECKER_MISR_EN
    , .sig_o(sig_a)
`endif
  );

  tt_sweep_checker #(.HOLD_CYCLES(2), .EXPECTED(16'hFFFF)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abc_o(abc_b), .d_i(d_b), .e_i(e_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b),
    .first_fail(ff_b), .table_o(tbl_b)
`ifdef TT_SWEEP_CHECKER_MISR_EN
    , .sig_o(sig_b)
`endif
  );

  tt_sweep_checker #(.HOLD_CYCLES(20), .EXPECTED(16'hB113)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abc_o(abc_c), .d_i(d_c), .e_i(e_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .fail_count(fc_c),
    .first_fail(ff_c), .table_o(tbl_c)
`ifdef TT_SWEEP_CHECKER_MISR_EN
    , .sig_o(sig_c)
`endif
  );

`ifndef TT_SWEEP_CHECKER_MISR_EN
  assign sig_a = 8'h00;
  assign sig_b = 8'h00;
  assign sig_c = 8'h00;
`endif

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Reference signature: seed FF, one step per vector in sweep order.
  function automatic logic [7:0] misr_of(input logic [15:0] t);
    logic [7:0] s;
    s = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00) ^ {6'b000000, t[2*i +: 2]};
    end
    return s;
  endfunction

  function automatic exp_t mk(input longint t0, input int lat, input logic p,
                              input logic [3:0] fc, input logic [2:0] ff,
                              input logic [15:0] tbl);
    exp_t e;
    e.t0 = t0; e.lat = lat; e.pass = p; e.fc = fc; e.ff = ff; e.tbl = tbl;
    e.sig = misr_of(tbl);
    return e;
  endfunction

  task automatic check_done(input string nm, input exp_t e, input logic p,
                            input logic [3:0] fc, input logic [2:0] ff,
                            input logic [15:0] tbl, input logic [7:0] sig);
    chk({nm, "_done_latency"}, (longint'($time) - e.t0 + 5) / 10, e.lat);
    chk({nm, "_pass"}, p, e.pass);
    chk({nm, "_fail_count"}, fc, e.fc);
    chk({nm, "_first_fail"}, ff, e.ff);
    chk({nm, "_table"}, tbl, e.tbl);
`ifdef TT_SWEEP_CHECKER_MISR_EN
    chk({nm, "_sig"}, sig, e.sig);
`endif
  endtask

  task automatic unexpected(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s_unexpected_done: got done=1, required done=0", nm);
  endtask

  task automatic chk_idle(input string nm, input logic [2:0] abc, input logic bsy,
                          input logic dn, input logic p, input logic [3:0] fc,
                          input logic [2:0] ff, input logic [15:0] tbl,
                          input logic [7:0] sig);
    chk({nm, "_rst_abc"}, abc, 0);
    chk({nm, "_rst_busy"}, bsy, 0);
    chk({nm, "_rst_done"}, dn, 0);
    chk({nm, "_rst_pass"}, p, 0);
    chk({nm, "_rst_fail_count"}, fc, 0);
    chk({nm, "_rst_first_fail"}, ff, 0);
    chk({nm, "_rst_table"}, tbl, 0);
`ifdef TT_SWEEP_CHECKER_MISR_EN
    chk({nm, "_rst_sig"}, sig, 8'hFF);
`endif
  endtask

  // Monitors: pop expected result on each done and check done width.
  always @(negedge clk) begin
    if (pd_a) chk("a_done_width", done_a, 0);
    pd_a <= done_a;
    if (done_a) begin
      sig_hist_a.push_back(sig_a);
      if (q_a.size() == 0) unexpected("a");
      else check_done("a", q_a.pop_front(), pass_a, fc_a, ff_a, tbl_a, sig_a);
    end
  end

  always @(negedge clk) begin
    if (pd_b) chk("b_done_width", done_b, 0);
    pd_b <= done_b;
    if (done_b) begin
      if (q_b.size() == 0) unexpected("b");
      else check_done("b", q_b.pop_front(), pass_b, fc_b, ff_b, tbl_b, sig_b);
    end
  end

  always @(negedge clk) begin
    if (pd_c) chk("c_done_width", done_c, 0);
    pd_c <= done_c;
    if (done_c) begin
      if (q_c.size() == 0) unexpected("c");
      else check_done("c", q_c.pop_front(), pass_c, fc_c, ff_c, tbl_c, sig_c);
    end
  end

  initial begin
    longint t0;
    int busy_cnt;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("a", abc_a, busy_a, done_a, pass_a, fc_a, ff_a, tbl_a, sig_a);
    chk_idle("b", abc_b, busy_b, done_b, pass_b, fc_b, ff_b, tbl_b, sig_b);
    chk_idle("c", abc_c, busy_c, done_c, pass_c, fc_c, ff_c, tbl_c, sig_c);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("a_no_start_idle", busy_a, 0);

    // Match (a), single mismatch (c), all mismatch with tied-low CUT (b).
    tie0_b = 1'b1;
    start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
    t0 = longint'($time) + 5;
    q_a.push_back(mk(t0, 161, 1'b1, 4'd0, 3'd0, 16'hB111));
    q_c.push_back(mk(t0, 161, 1'b0, 4'd1, 3'd0, 16'hB111));
    q_b.push_back(mk(t0, 17, 1'b0, 4'd8, 3'd0, 16'h0000));
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (170) @(negedge clk);
    chk("b_fail_count_held", fc_b, 8);
    chk("a_pass_held", pass_a, 1);

    // Vector timing at HOLD_CYCLES=2 with a start re-pulse mid-sweep.
    tie0_b = 1'b0;
    start_b = 1'b1;
    t0 = longint'($time) + 5;
    q_b.push_back(mk(t0, 17, 1'b0, 4'd7, 3'd0, 16'hB111));
    busy_cnt = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      start_b = (k == 5);
      if (busy_b) busy_cnt++;
      if (k <= 16) chk("b_abc_step", abc_b, (k - 1) / 2);
      if (k == 18) chk("b_abc_hold", abc_b, 7);
    end
    chk("b_busy_cycles", busy_cnt, 17);
    repeat (5) @(negedge clk);

    // Start held through DONE: back-to-back sweeps, then a flipped response.
    sig_hist_a.delete();
    start_a = 1'b1;
    t0 = longint'($time) + 5;
    q_a.push_back(mk(t0, 161, 1'b1, 4'd0, 3'd0, 16'hB111));
    q_a.push_back(mk(t0 + 1620, 161, 1'b1, 4'd0, 3'd0, 16'hB111));
    repeat (163) @(negedge clk);
    start_a = 1'b0;
    repeat (170) @(negedge clk);
    flip_a = 1'b1;
    start_a = 1'b1;
    t0 = longint'($time) + 5;
    q_a.push_back(mk(t0, 161, 1'b0, 4'd1, 3'd3, 16'hB151));
    @(negedge clk);
    start_a = 1'b0;
    repeat (170) @(negedge clk);
    flip_a = 1'b0;
`ifdef TT_SWEEP_CHECKER_MISR_EN
    chk("misr_sweep_count", sig_hist_a.size(), 3);
    if (sig_hist_a.size() == 3) begin
      chk("misr_repeat_same", sig_hist_a[1], sig_hist_a[0]);
      chk("misr_flip_differs", longint'(sig_hist_a[2] != sig_hist_a[0]), 1);
    end
`endif

    // Reset in the middle of vector 4 aborts without a done pulse.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (84) @(negedge clk);
    chk("a_pre_reset_abc", abc_a, 4);
    chk("a_pre_reset_table", tbl_a, 16'h0011);
    rst_n = 1'b0;
    #1;
    chk("a_mid_rst_abc", abc_a, 0);
    chk("a_mid_rst_busy", busy_a, 0);
    chk("a_mid_rst_table", tbl_a, 0);
    chk("a_mid_rst_done", done_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("a_post_rst_idle", busy_a, 0);
    start_a = 1'b1;
    t0 = longint'($time) + 5;
    q_a.push_back(mk(t0, 161, 1'b1, 4'd0, 3'd0, 16'hB111));
    @(negedge clk);
    start_a = 1'b0;
    repeat (170) @(negedge clk);

    // Every expected sweep must have completed.
    chk("a_pending_results", q_a.size(), 0);
    chk("b_pending_results", q_b.size(), 0);
    chk("c_pending_results", q_c.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tt_sweep_checker.md
TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 The block SHALL have the following parameters, one per line: name, default, meaning.
- HOLD_CYCLES, 20, cycles each input vector is held before sampling; legal range 2..255.
- EXPECTED, 16'h0000, golden truth table; bits [2i+1:2i] = {D,E} expected for vector i.
REQ-003 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- abc_o  output  3  stimulus to the circuit under test, {A,B,C}, with A as the MSB.
- d_i  input  1  response D from the circuit under test.
- e_i  input  1  response E from the circuit under test.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  result of the last sweep; valid from done until the next accepted start.
- fail_count  output  4  number of mismatching vectors in the last sweep (0..8).
- first_fail  output  3  index of the lowest mismatching vector; 0 if none.
- table_o  output  16  captured {D,E} table, in the same layout as EXPECTED.

Function
REQ-004 The block SHALL implement an FSM with three states: IDLE, DRIVE and DONE.
REQ-005 In IDLE with start=1, the block SHALL, on the next edge, enter DRIVE and perform all of the following:
- set vec=0 and hold_cnt=0;
- clear fail_count, first_fail, pass and table_o.
REQ-006 In DRIVE, abc_o SHALL equal vec, and hold_cnt SHALL increment on every cycle.
REQ-007 In DRIVE, when hold_cnt==HOLD_CYCLES-1, the block SHALL, on that edge, perform all of the following:
- write {d_i,e_i} into table_o[2*vec+1:2*vec];
- compare it against EXPECTED[2*vec+1:2*vec];
- on a mismatch, increment fail_count, and load first_fail with vec if this is the first mismatch;
- reset hold_cnt to 0.
REQ-008 After the sample in REQ-007:
- if vec<7, vec SHALL increment and the FSM SHALL stay in DRIVE;
- if vec==7, the FSM SHALL enter DONE.
REQ-009 Each vector SHALL be driven for exactly HOLD_CYCLES cycles, so DRIVE lasts exactly 8*HOLD_CYCLES cycles.
REQ-010 In DONE, the block SHALL assert done for exactly one cycle, set pass to (fail_count==0), and return to IDLE on the next edge.
REQ-011 busy SHALL be 1 in DRIVE and DONE, and 0 in IDLE.
REQ-012 start SHALL be ignored in DRIVE and DONE; a start held high through DONE SHALL launch a new sweep from IDLE on the following edge.
REQ-013 In IDLE and DONE, abc_o SHALL hold its last driven value.
REQ-014 pass, fail_count, first_fail and table_o SHALL hold their values until the next accepted start.
REQ-015 fail_count SHALL never exceed 8.

Reset
REQ-016 When rst_n=0, the block SHALL immediately enter IDLE and set every output and internal register to 0:
- abc_o=3'b000, busy=0, done=0, pass=0, fail_count=0, first_fail=0, table_o=16'h0000;
- vec=0, hold_cnt=0.
REQ-017 A reset during DRIVE SHALL abort the sweep, and no done pulse SHALL be produced.
REQ-018 After reset is released, the block SHALL require a new start before any sweep begins.

Configuration
REQ-019 When the macro TT_SWEEP_CHECKER_MISR_EN is defined, the block SHALL add the following:
- an output port sig_o, 8 bits wide;
- an 8-bit MISR with polynomial x^8+x^6+x^5+x^4+1, seeded to 8'hFF on an accepted start and on reset;
- at each sample, the MISR SHALL shift in {d_i,e_i} XORed into bits [1:0];
- sig_o SHALL be stable from done until the next accepted start.
REQ-020 When TT_SWEEP_CHECKER_MISR_EN is undefined, sig_o and the MISR logic SHALL be absent, with no other change in behaviour.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Sweep match: CUT is D=A&B, E=~C, EXPECTED=16'hB111, HOLD_CYCLES=20, start pulsed -> done exactly 161 cycles after the start edge, pass=1, fail_count=0, table_o=16'hB111.
- Single mismatch: same CUT, EXPECTED=16'hB113 -> pass=0, fail_count=1, first_fail=0, table_o=16'hB111.
- All mismatch: d_i and e_i tied to 0, EXPECTED=16'hFFFF -> fail_count=8, first_fail=0, pass=0.
- Vector timing: HOLD_CYCLES=2 -> abc_o steps 0,1,...,7 at 2-cycle intervals; start re-pulsed mid-sweep is ignored; busy is high for 17 cycles.
- Reset mid-sweep: rst_n=0 while vec=4 -> abc_o=0, busy=0, table_o=0 immediately, and no done pulse; a new start then runs a full sweep.
- MISR (with TT_SWEEP_CHECKER_MISR_EN defined): two identical sweeps -> identical sig_o; flipping one response bit -> different sig_o.
